// File: rtl/pipelined_mem_model_if.sv
// Processor-to-memory bus for pipelined_mem_model: request fields driven by the
// requester, tagged response/completion fields driven by the memory.
interface pipelined_mem_model_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) ();
  logic [ADDR_W-1:0] proc2mem_addr;
  logic [DATA_W-1:0] proc2mem_data;
  logic [1:0]        proc2mem_command;
  logic [TAG_W-1:0]  mem2proc_response;
  logic [DATA_W-1:0] mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_tag;
  logic              mem2proc_err;

  modport master (
    output proc2mem_addr, proc2mem_data, proc2mem_command,
    input  mem2proc_response, mem2proc_data, mem2proc_tag, mem2proc_err
  );

  modport slave (
    input  proc2mem_addr, proc2mem_data, proc2mem_command,
    output mem2proc_response, mem2proc_data, mem2proc_tag, mem2proc_err
  );
endinterface

// File: rtl/pipelined_mem_model.sv
// Tagged fixed-latency unified memory: one LOAD/STORE per cycle, in-order completions.
// Optional address legality checking is enabled by defining MEM_ADDR_CHK_EN.
module pipelined_mem_model #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 4,
  parameter int TAG_W       = 4
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_mem_model_if.slave bus
);
  localparam int OFS_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int NTAGS = (1 << TAG_W) - 1;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_STORE = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  logic [DATA_W-1:0] unified_memory [DEPTH_WORDS];

  logic [TAG_W-1:0]  r_pipeTag  [LATENCY];
  logic [DATA_W-1:0] r_pipeData [LATENCY];
  logic [NTAGS:1]    r_busy;
  logic [TAG_W-1:0]  r_response;
  logic              r_err;

  logic [NTAGS:1]    w_avail;
  logic [NTAGS:1]    w_busyNext;
  logic [TAG_W-1:0]  w_allocTag;
  logic [TAG_W-1:0]  w_relTag;
  logic [IDX_W-1:0]  w_idx;
  logic              w_found;
  logic              w_isLoad;
  logic              w_isStore;
  logic              w_legal;
  logic              w_loadOk;
  logic              w_storeOk;

  assign w_idx     = bus.proc2mem_addr[OFS_W +: IDX_W];
  assign w_isLoad  = (cmd_e'(bus.proc2mem_command) == CMD_LOAD);
  assign w_isStore = (cmd_e'(bus.proc2mem_command) == CMD_STORE);

`ifdef MEM_ADDR_CHK_EN
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((64'd1 << OFS_W) - 64'd1);
  assign w_legal = ((bus.proc2mem_addr & OFS_MASK) == '0) &&
                   ((bus.proc2mem_addr >> (OFS_W + IDX_W)) == '0);
`else
  assign w_legal = 1'b1;
`endif

  // The tag leaving the last stage is released on this edge and may be reallocated at once.
  assign w_relTag  = r_pipeTag[LATENCY-1];
  assign w_loadOk  = w_isLoad && w_legal && w_found;
  assign w_storeOk = w_isStore && w_legal;

  always_comb begin
    w_avail    = '0;
    w_allocTag = '0;
    w_found    = 1'b0;
    for (int t = 1; t <= NTAGS; t++) begin
      w_avail[t] = !r_busy[t] || (w_relTag == TAG_W'(t));
    end
    for (int t = 1; t <= NTAGS; t++) begin
      if (!w_found && w_avail[t]) begin
        w_allocTag = TAG_W'(t);
        w_found    = 1'b1;
      end
    end
  end

  always_comb begin
    w_busyNext = '0;
    for (int t = 1; t <= NTAGS; t++) begin
      w_busyNext[t] = !w_avail[t] || (w_loadOk && (w_allocTag == TAG_W'(t)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_response <= '0;
      r_err      <= 1'b0;
      for (int s = 0; s < LATENCY; s++) begin
        r_pipeTag[s]  <= '0;
        r_pipeData[s] <= '0;
      end
    end else begin
      r_busy        <= w_busyNext;
      r_response    <= w_loadOk ? w_allocTag : '0;
      r_err         <= (w_isLoad || w_isStore) && !w_legal;
      r_pipeTag[0]  <= w_loadOk ? w_allocTag : '0;
      r_pipeData[0] <= w_loadOk ? unified_memory[w_idx] : '0;
      for (int s = 1; s < LATENCY; s++) begin
        r_pipeTag[s]  <= r_pipeTag[s-1];
        r_pipeData[s] <= r_pipeData[s-1];
      end
    end
  end

  // Memory contents survive reset so preloaded images stay intact.
  always_ff @(posedge clk) begin
    if (w_storeOk) begin
      unified_memory[w_idx] <= bus.proc2mem_data;
    end
  end

  assign bus.mem2proc_response = r_response;
  assign bus.mem2proc_tag      = r_pipeTag[LATENCY-1];
  assign bus.mem2proc_data     = r_pipeData[LATENCY-1];
  assign bus.mem2proc_err      = r_err;
endmodule

// File: tb/tb_pipelined_mem_model.sv
// Directed bench for pipelined_mem_model: a TAG_W=4 instance for the main scenarios
// and a TAG_W=2 instance for tag exhaustion; honours MEM_ADDR_CHK_EN.
module tb_pipelined_mem_model;
  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_LOAD  = 2'b01;
  localparam logic [1:0] C_STORE = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pipelined_mem_model_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(4)) busA ();
  pipelined_mem_model_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(2)) busB ();

  pipelined_mem_model #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(16384), .LATENCY(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .bus(busA)
  );

  pipelined_mem_model #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(64), .LATENCY(4), .TAG_W(2)) dutB (
    .clk(clk), .rst(rst), .bus(busB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveA(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    busA.proc2mem_command = cmd;
    busA.proc2mem_addr    = addr;
    busA.proc2mem_data    = data;
  endtask

  task automatic driveB(input logic [1:0] cmd, input logic [31:0] addr);
    busB.proc2mem_command = cmd;
    busB.proc2mem_addr    = addr;
    busB.proc2mem_data    = 32'h0;
  endtask

  task automatic test_reset();
    driveA(C_LOAD, 32'h10, 32'h0);
    driveB(C_LOAD, 32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({busA.mem2proc_response, busA.mem2proc_tag, busA.mem2proc_data, busA.mem2proc_err} !== '0) begin
        bad++;
        $display("[TB] FAIL reset_outputs cyc%0d: resp=%0d tag=%0d data=%h err=%b, required all 0",
                 i, busA.mem2proc_response, busA.mem2proc_tag, busA.mem2proc_data, busA.mem2proc_err);
      end
    end
    driveA(C_NONE, 32'h0, 32'h0);
    driveB(C_NONE, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (busA.mem2proc_tag !== 4'd0 || busA.mem2proc_response !== 4'd0) begin
        bad++;
        $display("[TB] FAIL reset_no_completion cyc%0d: tag=%0d resp=%0d, required 0/0",
                 i, busA.mem2proc_tag, busA.mem2proc_response);
      end
    end
  endtask

  task automatic test_latency();
    driveA(C_STORE, 32'h10, 32'hDEADBEEF);
    tick();
    driveA(C_LOAD, 32'h10, 32'h0);
    tick();
    total++;
    if (busA.mem2proc_response !== 4'd1 || busA.mem2proc_tag !== 4'd0) begin
      bad++;
      $display("[TB] FAIL latency_resp: resp=%0d tag=%0d, required 1/0",
               busA.mem2proc_response, busA.mem2proc_tag);
    end
    driveA(C_NONE, 32'h0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (busA.mem2proc_tag !== ((i == 3) ? 4'd1 : 4'd0)) begin
        bad++;
        $display("[TB] FAIL latency_tag step%0d: tag=%0d, required %0d",
                 i, busA.mem2proc_tag, (i == 3) ? 1 : 0);
      end
      if (i == 3) begin
        total++;
        if (busA.mem2proc_data !== 32'hDEADBEEF) begin
          bad++;
          $display("[TB] FAIL latency_data: data=%h, required deadbeef", busA.mem2proc_data);
        end
      end
    end
  endtask

  task automatic test_streaming();
    int          expResp [9] = '{1, 2, 3, 4, 1, 0, 0, 0, 0};
    int          expTag  [9] = '{0, 0, 0, 1, 2, 3, 4, 1, 0};
    logic [31:0] expData [9] = '{0, 0, 0, 32'h100, 32'h101, 32'h102, 32'h103, 32'h100, 0};
    for (int i = 0; i < 4; i++) begin
      driveA(C_STORE, 32'(4 * i), 32'h100 + 32'(i));
      tick();
    end
    for (int j = 0; j < 9; j++) begin
      if (j < 4)       driveA(C_LOAD, 32'(4 * j), 32'h0);
      else if (j == 4) driveA(C_LOAD, 32'h0, 32'h0);
      else             driveA(C_NONE, 32'h0, 32'h0);
      tick();
      total++;
      if (busA.mem2proc_response !== 4'(expResp[j]) || busA.mem2proc_tag !== 4'(expTag[j])) begin
        bad++;
        $display("[TB] FAIL stream step%0d: resp=%0d tag=%0d, required %0d/%0d",
                 j, busA.mem2proc_response, busA.mem2proc_tag, expResp[j], expTag[j]);
      end
      if (expTag[j] != 0) begin
        total++;
        if (busA.mem2proc_data !== expData[j]) begin
          bad++;
          $display("[TB] FAIL stream_data step%0d: data=%h, required %h", j, busA.mem2proc_data, expData[j]);
        end
      end
    end
  endtask

  task automatic test_exhaustion();
    int expResp [9] = '{1, 2, 3, 0, 1, 0, 0, 0, 0};
    int expTag  [9] = '{0, 0, 0, 1, 2, 3, 0, 1, 0};
    for (int j = 0; j < 9; j++) begin
      if (j < 4)       driveB(C_LOAD, 32'(4 * j));
      else if (j == 4) driveB(C_LOAD, 32'hC);
      else             driveB(C_NONE, 32'h0);
      tick();
      total++;
      if (busB.mem2proc_response !== 2'(expResp[j]) || busB.mem2proc_tag !== 2'(expTag[j])) begin
        bad++;
        $display("[TB] FAIL exhaust step%0d: resp=%0d tag=%0d, required %0d/%0d",
                 j, busB.mem2proc_response, busB.mem2proc_tag, expResp[j], expTag[j]);
      end
    end
  endtask

  task automatic test_store_load();
    driveA(C_STORE, 32'h20, 32'hA5A5A5A5);
    tick();
    total++;
    if (busA.mem2proc_response !== 4'd0) begin
      bad++;
      $display("[TB] FAIL store_resp: resp=%0d, required 0", busA.mem2proc_response);
    end
    driveA(C_LOAD, 32'h20, 32'h0);
    tick();
    total++;
    if (busA.mem2proc_response !== 4'd1) begin
      bad++;
      $display("[TB] FAIL store_load_resp: resp=%0d, required 1", busA.mem2proc_response);
    end
    driveA(C_STORE, 32'h20, 32'h1);
    tick();
    driveA(C_NONE, 32'h0, 32'h0);
    tick();
    tick();
    total++;
    if (busA.mem2proc_tag !== 4'd1 || busA.mem2proc_data !== 32'hA5A5A5A5) begin
      bad++;
      $display("[TB] FAIL snapshot: tag=%0d data=%h, required 1/a5a5a5a5", busA.mem2proc_tag, busA.mem2proc_data);
    end
    driveA(C_LOAD, 32'h20, 32'h0);
    tick();
    driveA(C_NONE, 32'h0, 32'h0);
    tick(); tick(); tick();
    total++;
    if (busA.mem2proc_tag !== 4'd1 || busA.mem2proc_data !== 32'h1) begin
      bad++;
      $display("[TB] FAIL reload_new: tag=%0d data=%h, required 1/00000001", busA.mem2proc_tag, busA.mem2proc_data);
    end
`ifndef MEM_ADDR_CHK_EN
    driveA(C_LOAD, 32'h40000020, 32'h0);
    tick();
    driveA(C_NONE, 32'h0, 32'h0);
    tick(); tick(); tick();
    total++;
    if (busA.mem2proc_tag !== 4'd1 || busA.mem2proc_data !== 32'h1 || busA.mem2proc_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL addr_wrap: tag=%0d data=%h err=%b, required 1/00000001/0",
               busA.mem2proc_tag, busA.mem2proc_data, busA.mem2proc_err);
    end
`endif
    tick();
  endtask

  task automatic test_midflight_reset();
    driveA(C_LOAD, 32'h0, 32'h0);
    tick();
    driveA(C_LOAD, 32'h4, 32'h0);
    tick();
    driveA(C_NONE, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    total++;
    if (busA.mem2proc_response !== 4'd0 || busA.mem2proc_tag !== 4'd0) begin
      bad++;
      $display("[TB] FAIL async_reset: resp=%0d tag=%0d, required 0/0", busA.mem2proc_response, busA.mem2proc_tag);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (busA.mem2proc_tag !== 4'd0) begin
        bad++;
        $display("[TB] FAIL dropped_loads cyc%0d: tag=%0d, required 0", i, busA.mem2proc_tag);
      end
    end
    driveA(C_LOAD, 32'h8, 32'h0);
    tick();
    total++;
    if (busA.mem2proc_response !== 4'd1) begin
      bad++;
      $display("[TB] FAIL post_reset_tag: resp=%0d, required 1", busA.mem2proc_response);
    end
    driveA(C_NONE, 32'h0, 32'h0);
    tick(); tick(); tick();
    total++;
    if (busA.mem2proc_tag !== 4'd1 || busA.mem2proc_data !== 32'h102) begin
      bad++;
      $display("[TB] FAIL post_reset_data: tag=%0d data=%h, required 1/00000102", busA.mem2proc_tag, busA.mem2proc_data);
    end
    tick();
  endtask

  task automatic test_addr_check();
    driveA(C_LOAD, 32'h13, 32'h0);
    tick();
`ifdef MEM_ADDR_CHK_EN
    total++;
    if (busA.mem2proc_response !== 4'd0 || busA.mem2proc_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL chk_misaligned: resp=%0d err=%b, required 0/1", busA.mem2proc_response, busA.mem2proc_err);
    end
    driveA(C_STORE, 32'h40000020, 32'h77);
    tick();
    total++;
    if (busA.mem2proc_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL chk_high_store: err=%b, required 1", busA.mem2proc_err);
    end
    driveA(C_LOAD, 32'h20, 32'h0);
    tick();
    total++;
    if (busA.mem2proc_response !== 4'd1 || busA.mem2proc_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL chk_legal_load: resp=%0d err=%b, required 1/0", busA.mem2proc_response, busA.mem2proc_err);
    end
    driveA(C_NONE, 32'h0, 32'h0);
    tick(); tick(); tick();
    total++;
    if (busA.mem2proc_tag !== 4'd1 || busA.mem2proc_data !== 32'h1) begin
      bad++;
      $display("[TB] FAIL chk_no_write: tag=%0d data=%h, required 1/00000001", busA.mem2proc_tag, busA.mem2proc_data);
    end
`else
    total++;
    if (busA.mem2proc_response !== 4'd1 || busA.mem2proc_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL unaligned_load: resp=%0d err=%b, required 1/0", busA.mem2proc_response, busA.mem2proc_err);
    end
    driveA(C_NONE, 32'h0, 32'h0);
    tick(); tick(); tick();
    total++;
    if (busA.mem2proc_tag !== 4'd1 || busA.mem2proc_data !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL unaligned_data: tag=%0d data=%h, required 1/deadbeef", busA.mem2proc_tag, busA.mem2proc_data);
    end
`endif
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting pipelined_mem_model bench");
    test_reset();
    test_latency();
    test_streaming();
    test_exhaustion();
    test_store_load();
    test_midflight_reset();
    test_addr_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
